// File: rtl/spi_pkg.sv
// Shared types and frame-length helpers for the SPI host sequencer.
//   cmd_e         : 2-bit command placed in front of every frame payload
//   ctrl_state_e  : sequencer states
//   *_frame_len   : number of SS_n-low cycles per frame type
package spi_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_FRM,
    GAP_WAIT,
    DATA_FRM,
    RD_CAP,
    DONE
  } ctrl_state_e;

  // Select bit, W+2 command/payload bits, one trailing zero.
  function automatic int short_frame_len(input int w);
    return w + 4;
  endfunction

  // Command part, read latency, then W returned bits (last bit on the final low cycle).
  function automatic int read_frame_len(input int w, input int rd_lat);
    return 2 * w + rd_lat + 3;
  endfunction

  function automatic int frame_cnt_width(input int w, input int rd_lat);
    return $clog2(2 * w + rd_lat + 5);
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Serialises one frame word onto MOSI and deserialises the read reply from MISO.
//   clk_i, rst_n_i : clock, async active-low reset
//   start_i        : load word_i; the next cycle is the first SS_n-low cycle
//   word_i         : {cmd[1:0], payload[W-1:0]}
//   long_i         : frame is a RD_DATA frame (extended to capture the reply)
//   miso_i         : serial data from slave
//   mosi_o         : registered serial data to slave
//   cmd_end_o      : current cycle is the last cycle of the command part
//   frame_done_o   : current cycle is the last low cycle of the frame
//   rx_next_o      : reply word including the bit sampled this cycle
module spi_frame_shifter
  import spi_pkg::*;
#(
  parameter int W      = 8,
  parameter int RD_LAT = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [W+1:0] word_i,
  input  logic         long_i,
  input  logic         miso_i,
  output logic         mosi_o,
  output logic         cmd_end_o,
  output logic         frame_done_o,
  output logic [W-1:0] rx_next_o
);

  localparam int CW = frame_cnt_width(W, RD_LAT);
  localparam logic [CW-1:0] CMD_LAST  = CW'(short_frame_len(W) - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(read_frame_len(W, RD_LAT) - 1);
  localparam logic [CW-1:0] CAP_FIRST = CW'(W + 3 + RD_LAT);

  logic          active_q, active_d;
  logic          long_q, long_d;
  logic          mosi_q, mosi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W+1:0]  word_q, word_d;
  logic [W-2:0]  rx_q, rx_d;
  logic          last_c;

  assign last_c       = active_q && (cnt_q == (long_q ? LONG_LAST : CMD_LAST));
  assign frame_done_o = last_c;
  assign cmd_end_o    = active_q && (cnt_q == CMD_LAST);
  assign rx_next_o    = {rx_q, miso_i};
  assign mosi_o       = mosi_q;

  // cnt_q is the 0-based index of the current low cycle. The select bit is
  // shown on the first cycle and repeated on the second, because the word is
  // only shifted after it has been presented twice; zeros then fill in behind.
  always_comb begin
    active_d = active_q;
    long_d   = long_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    rx_d     = rx_q;
    mosi_d   = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      long_d   = long_i;
      cnt_d    = '0;
      word_d   = word_i;
      rx_d     = '0;
      mosi_d   = word_i[W+1];
    end else if (active_q) begin
      if (long_q && (cnt_q >= CAP_FIRST)) begin
        rx_d = rx_next_o[W-2:0];
      end
      if (last_c) begin
        active_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        mosi_d = word_q[W+1];
        word_d = {word_q[W:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_q <= 1'b0;
      long_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cnt_q    <= '0;
      word_q   <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      long_q   <= long_d;
      mosi_q   <= mosi_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side sequencer: turns one memory request into an address frame and a
// data frame towards the SPI slave/RAM wrapper; reads return the captured word.
//   clk_i, rst_n_i : clock, async active-low reset
//   req_valid_i/req_ready_o, req_write_i, req_addr_i, req_wdata_i : request
//   rsp_valid_o    : one-cycle pulse, read data valid
//   rsp_rdata_o    : last read data, held until the next read completes
//   busy_o         : operation in progress
//   ss_n_o, mosi_o, miso_i : SPI lines (ss_n_o and mosi_o registered)
//
// state    | meaning
// IDLE     | SS_n high, ready for a request
// ADDR_FRM | sending WR_ADDR / RD_ADDR frame
// GAP_WAIT | SS_n high between the two frames
// DATA_FRM | sending WR_DATA frame, or command part of RD_DATA frame
// RD_CAP   | RD_DATA frame kept open for latency + reply bits
// DONE     | SS_n high for one cycle, read response presented
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter  int MEM_DEPTH = 256,
  parameter  int RD_LAT    = 2,
  parameter  int GAP       = 1,
  localparam int W         = $clog2(MEM_DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_write_i,
  input  logic [W-1:0] req_addr_i,
  input  logic [W-1:0] req_wdata_i,
  output logic         rsp_valid_o,
  output logic [W-1:0] rsp_rdata_o,
  output logic         busy_o,
  output logic         ss_n_o,
  output logic         mosi_o,
  input  logic         miso_i
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  ctrl_state_e state_q, state_d;
  logic             ss_n_q, ss_n_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             wr_q, wr_d;
  logic [W-1:0]     addr_q, addr_d;
  logic [W-1:0]     wdata_q, wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic             frm_start;
  logic             frm_long;
  cmd_e             frm_cmd;
  logic [W-1:0]     frm_payload;
  logic [W+1:0]     frm_word;
  logic             frm_cmd_end;
  logic             frm_done;
  logic [W-1:0]     frm_rx_next;

  assign frm_word = {frm_cmd, frm_payload};

  spi_frame_shifter #(
    .W      (W),
    .RD_LAT (RD_LAT)
  ) u_shifter (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (frm_start),
    .word_i       (frm_word),
    .long_i       (frm_long),
    .miso_i       (miso_i),
    .mosi_o       (mosi_o),
    .cmd_end_o    (frm_cmd_end),
    .frame_done_o (frm_done),
    .rx_next_o    (frm_rx_next)
  );

  always_comb begin
    state_d     = state_q;
    ss_n_d      = ss_n_q;
    gap_d       = gap_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    frm_start   = 1'b0;
    frm_long    = 1'b0;
    frm_cmd     = WR_ADDR;
    frm_payload = '0;
    unique case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        if (req_valid_i) begin
          wr_d        = req_write_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          frm_start   = 1'b1;
          frm_cmd     = req_write_i ? WR_ADDR : RD_ADDR;
          frm_payload = req_addr_i;
          ss_n_d      = 1'b0;
          state_d     = ADDR_FRM;
        end
      end
      ADDR_FRM: begin
        if (frm_done) begin
          ss_n_d  = 1'b1;
          gap_d   = GAP_W'(GAP - 1);
          state_d = GAP_WAIT;
        end
      end
      GAP_WAIT: begin
        if (gap_q == '0) begin
          frm_start   = 1'b1;
          frm_long    = !wr_q;
          frm_cmd     = wr_q ? WR_DATA : RD_DATA;
          frm_payload = wr_q ? wdata_q : '0;
          ss_n_d      = 1'b0;
          state_d     = DATA_FRM;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DATA_FRM: begin
        if (!wr_q) begin
          if (frm_cmd_end) state_d = RD_CAP;
        end else if (frm_done) begin
          ss_n_d  = 1'b1;
          state_d = DONE;
        end
      end
      RD_CAP: begin
        // The last reply bit is on MISO now; take it straight into the response.
        if (frm_done) begin
          ss_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = frm_rx_next;
          state_d     = DONE;
        end
      end
      DONE: begin
        ss_n_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ss_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ss_n_q      <= 1'b1;
      gap_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ss_n_q      <= ss_n_d;
      gap_q       <= gap_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign ss_n_o      = ss_n_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  logic       clk, rst_n;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata, rsp_rdata;
  logic       rsp_valid, busy, ss_n, mosi, miso;

  int n_vec = 0;
  int n_err = 0;

  spi_master_ctrl #(.MEM_DEPTH(256), .RD_LAT(2), .GAP(1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .busy_o      (busy),
    .ss_n_o      (ss_n),
    .mosi_o      (mosi),
    .miso_i      (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave + RAM model: decodes each frame and logs word, length, gap, protocol errors.
  logic [7:0] mem [256];
  logic [9:0] s_sh;
  logic [7:0] waddr, raddr, rd_sh;
  logic       first_bit, bad;
  int         s_cnt, hi_cnt;
  logic [9:0] f_word_q [$];
  int         f_len_q [$];
  logic       f_bad_q [$];
  int         gap_q [$];
  logic [7:0] rsp_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= 0; hi_cnt <= 0; miso <= 1'b0; bad <= 1'b0; first_bit <= 1'b0; rd_sh <= 8'h00;
    end else if (ss_n) begin
      if (s_cnt != 0) begin
        f_word_q.push_back(s_sh);
        f_len_q.push_back(s_cnt);
        f_bad_q.push_back(bad);
        hi_cnt <= 1;
      end else begin
        hi_cnt <= hi_cnt + 1;
      end
      s_cnt <= 0; miso <= 1'b0; bad <= 1'b0;
    end else begin
      if (s_cnt == 0) begin
        gap_q.push_back(hi_cnt);
        first_bit <= mosi;
      end
      s_cnt <= s_cnt + 1;
      if (s_cnt == 1 && mosi !== first_bit) bad <= 1'b1;
      if (s_cnt >= 1 && s_cnt <= 10) s_sh <= {s_sh[8:0], mosi};
      if (s_cnt >= 11 && mosi !== 1'b0) bad <= 1'b1;
      if (s_cnt == 11) begin
        case (s_sh[9:8])
          2'b00: waddr <= s_sh[7:0];
          2'b01: mem[waddr] = s_sh[7:0];
          2'b10: raddr <= s_sh[7:0];
          default: ;
        endcase
        rd_sh <= (s_sh[9:8] == 2'b11) ? mem[raddr] : 8'h00;
      end
      if (s_cnt >= 12 && s_cnt <= 19) begin
        miso  <= rd_sh[7];
        rd_sh <= {rd_sh[6:0], 1'b0};
      end else begin
        miso <= 1'b0;
      end
    end
  end

  always @(posedge clk) if (rst_n && rsp_valid) rsp_q.push_back(rsp_rdata);

  task automatic clear_logs();
    f_word_q.delete(); f_len_q.delete(); f_bad_q.delete(); gap_q.delete(); rsp_q.delete();
  endtask

  task automatic do_op(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL op_timeout: busy=%b after %0d cycles, want 0", busy, t); end
  endtask

  // First request accepted, then req_valid stays high with the second request.
  task automatic pair_ops(input logic wr1, input logic [7:0] a1, input logic [7:0] d1,
                          input logic wr2, input logic [7:0] a2, input logic [7:0] d2,
                          output int t1, output int viol, output logic rdy_idle, output logic acc2);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr1; req_addr = a1; req_wdata = d1;
    @(negedge clk);
    req_write = wr2; req_addr = a2; req_wdata = d2;
    t1 = 0; viol = 0;
    while (busy && t1 < 100) begin
      if (req_ready) viol++;
      @(negedge clk);
      t1++;
    end
    rdy_idle = req_ready;
    @(negedge clk);
    acc2 = busy;
    req_valid = 1'b0;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL pair_timeout: busy=%b after %0d cycles, want 0", busy, t); end
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (ss_n !== 1'b1)      begin n_err++; $display("FAIL rst_ss_n: got %b want 1", ss_n); end
    n_vec++; if (mosi !== 1'b0)      begin n_err++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write();
    logic [9:0] exp_w [2] = '{10'h03C, 10'h1A5};
    clear_logs();
    do_op(1'b1, 8'h3C, 8'hA5);
    n_vec++;
    if (f_word_q.size() != 2) begin n_err++; $display("FAIL wr_frames: got %0d want 2", f_word_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        n_vec++; if (f_word_q[i] !== exp_w[i]) begin n_err++; $display("FAIL wr_word%0d: got %b want %b", i, f_word_q[i], exp_w[i]); end
        n_vec++; if (f_len_q[i] != 12) begin n_err++; $display("FAIL wr_len%0d: got %0d want 12", i, f_len_q[i]); end
        n_vec++; if (f_bad_q[i] !== 1'b0) begin n_err++; $display("FAIL wr_bits%0d: select/trailer error got %b want 0", i, f_bad_q[i]); end
      end
      n_vec++; if (gap_q[1] != 1) begin n_err++; $display("FAIL wr_gap: got %0d want 1", gap_q[1]); end
    end
    n_vec++; if (rsp_q.size() != 0) begin n_err++; $display("FAIL wr_no_rsp: got %0d pulses want 0", rsp_q.size()); end
  endtask

  task automatic test_read();
    logic [9:0] exp_w [2] = '{10'h23C, 10'h300};
    int         exp_l [2] = '{12, 21};
    clear_logs();
    do_op(1'b0, 8'h3C, 8'h00);
    n_vec++;
    if (rsp_q.size() != 1) begin n_err++; $display("FAIL rd_rsp_count: got %0d want 1", rsp_q.size()); end
    else begin
      n_vec++; if (rsp_q[0] !== 8'hA5) begin n_err++; $display("FAIL rd_rsp_data: got %h want a5", rsp_q[0]); end
    end
    n_vec++; if (rsp_rdata !== 8'hA5) begin n_err++; $display("FAIL rd_rsp_hold: got %h want a5", rsp_rdata); end
    n_vec++;
    if (f_word_q.size() != 2) begin n_err++; $display("FAIL rd_frames: got %0d want 2", f_word_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        n_vec++; if (f_word_q[i] !== exp_w[i]) begin n_err++; $display("FAIL rd_word%0d: got %b want %b", i, f_word_q[i], exp_w[i]); end
        n_vec++; if (f_len_q[i] != exp_l[i]) begin n_err++; $display("FAIL rd_len%0d: got %0d want %0d", i, f_len_q[i], exp_l[i]); end
        n_vec++; if (f_bad_q[i] !== 1'b0) begin n_err++; $display("FAIL rd_bits%0d: got %b want 0", i, f_bad_q[i]); end
      end
      n_vec++; if (gap_q[1] != 1) begin n_err++; $display("FAIL rd_gap: got %0d want 1", gap_q[1]); end
    end
  endtask

  task automatic test_read_untouched();
    clear_logs();
    do_op(1'b0, 8'h00, 8'h00);
    n_vec++;
    if (rsp_q.size() != 1) begin n_err++; $display("FAIL rd0_rsp_count: got %0d want 1", rsp_q.size()); end
    else begin
      n_vec++; if (rsp_q[0] !== 8'h00) begin n_err++; $display("FAIL rd0_rsp_data: got %h want 00", rsp_q[0]); end
    end
    do_op(1'b1, 8'h10, 8'h77);
    n_vec++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL rd0_hold_after_wr: got %h want 00", rsp_rdata); end
    n_vec++; if (rsp_q.size() != 1) begin n_err++; $display("FAIL rd0_wr_no_rsp: got %0d pulses want 1", rsp_q.size()); end
  endtask

  task automatic test_busy_hold();
    int t1, viol;
    logic rdy_idle, acc2;
    logic [9:0] exp_w [4] = '{10'h020, 10'h111, 10'h220, 10'h300};
    int         exp_g [4] = '{0, 1, 2, 1};
    clear_logs();
    pair_ops(1'b1, 8'h20, 8'h11, 1'b0, 8'h20, 8'h00, t1, viol, rdy_idle, acc2);
    n_vec++; if (t1 != 26) begin n_err++; $display("FAIL hold_busy_len: got %0d want 26", t1); end
    n_vec++; if (viol != 0) begin n_err++; $display("FAIL hold_ready_busy: ready high %0d busy cycles want 0", viol); end
    n_vec++; if (rdy_idle !== 1'b1) begin n_err++; $display("FAIL hold_ready_done1: got %b want 1", rdy_idle); end
    n_vec++; if (acc2 !== 1'b1) begin n_err++; $display("FAIL hold_accept2: busy got %b want 1", acc2); end
    n_vec++;
    if (f_word_q.size() != 4) begin n_err++; $display("FAIL hold_frames: got %0d want 4", f_word_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (f_word_q[i] !== exp_w[i]) begin n_err++; $display("FAIL hold_word%0d: got %b want %b", i, f_word_q[i], exp_w[i]); end
      end
      for (int i = 1; i < 4; i++) begin
        n_vec++; if (gap_q[i] != exp_g[i]) begin n_err++; $display("FAIL hold_gap%0d: got %0d want %0d", i, gap_q[i], exp_g[i]); end
      end
    end
    n_vec++;
    if (rsp_q.size() != 1) begin n_err++; $display("FAIL hold_rsp_count: got %0d want 1", rsp_q.size()); end
    else begin
      n_vec++; if (rsp_q[0] !== 8'h11) begin n_err++; $display("FAIL hold_rsp_data: got %h want 11", rsp_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int t1, viol;
    logic rdy_idle, acc2;
    logic [7:0] exp_r [2] = '{8'h5A, 8'hC3};
    logic [9:0] exp_w [4] = '{10'h2FF, 10'h300, 10'h201, 10'h300};
    do_op(1'b1, 8'hFF, 8'h5A);
    do_op(1'b1, 8'h01, 8'hC3);
    clear_logs();
    pair_ops(1'b0, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h00, t1, viol, rdy_idle, acc2);
    n_vec++; if (t1 != 35) begin n_err++; $display("FAIL b2b_busy_len: got %0d want 35", t1); end
    n_vec++; if (viol != 0) begin n_err++; $display("FAIL b2b_ready_busy: ready high %0d busy cycles want 0", viol); end
    n_vec++; if (acc2 !== 1'b1) begin n_err++; $display("FAIL b2b_accept2: busy got %b want 1", acc2); end
    n_vec++;
    if (rsp_q.size() != 2) begin n_err++; $display("FAIL b2b_rsp_count: got %0d want 2", rsp_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        n_vec++; if (rsp_q[i] !== exp_r[i]) begin n_err++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rsp_q[i], exp_r[i]); end
      end
    end
    n_vec++;
    if (f_word_q.size() != 4) begin n_err++; $display("FAIL b2b_frames: got %0d want 4", f_word_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (f_word_q[i] !== exp_w[i]) begin n_err++; $display("FAIL b2b_word%0d: got %b want %b", i, f_word_q[i], exp_w[i]); end
      end
      n_vec++; if (gap_q[2] != 2) begin n_err++; $display("FAIL b2b_op_gap: got %0d want 2", gap_q[2]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h3C; req_wdata = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (28) @(negedge clk);
    n_vec++; if (ss_n !== 1'b0) begin n_err++; $display("FAIL mid_in_frame: ss_n got %b want 0", ss_n); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (ss_n !== 1'b1)       begin n_err++; $display("FAIL mid_ss_n: got %b want 1", ss_n); end
    n_vec++; if (mosi !== 1'b0)       begin n_err++; $display("FAIL mid_mosi: got %b want 0", mosi); end
    n_vec++; if (rsp_valid !== 1'b0)  begin n_err++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL mid_rsp_rdata: got %h want 00", rsp_rdata); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_req_ready: got %b want 1", req_ready); end
    repeat (40) @(negedge clk);
    n_vec++; if (rsp_q.size() != 0) begin n_err++; $display("FAIL mid_no_rsp: got %0d pulses want 0", rsp_q.size()); end
    n_vec++; if (f_word_q.size() != 1) begin n_err++; $display("FAIL mid_frames: got %0d completed want 1", f_word_q.size()); end
    n_vec++; if (ss_n !== 1'b1) begin n_err++; $display("FAIL mid_ss_n_idle: got %b want 1", ss_n); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_read_untouched();
    test_busy_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
